// File: rtl/interval_timer_pkg.sv
// Shared types and defaults for the interval timer and the button-sequencing FSM top level.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package timer_pkg;

  // One-hot state encoding; any other value is treated as illegal and recovers to IDLE.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RUN  = 3'b010,
    DONE = 3'b100
  } state_t;

  // 1 ms ticks from a 50 MHz clock.
  localparam int DEF_PRESCALE = 50_000;
  localparam int DEF_WIDTH    = 16;

  // Prescaler width; a divide-by-1 prescaler still gets a 1-bit register.
  function automatic int presc_width(input int prescale);
    return (prescale < 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/interval_timer_if.sv
// Control/status bundle between the sequencing FSM (master) and the interval timer (slave).
// Latency: n/a (wires only).
// Backpressure: none; START/CLR are single-cycle pulses, READY/BUSY/COUNT are levels.
interface interval_timer_if #(
  parameter int WIDTH = timer_pkg::DEF_WIDTH
);

  logic             CLR;
  logic             START;
  logic [WIDTH-1:0] DELAY;
  logic             READY;
  logic             BUSY;
  logic [WIDTH-1:0] COUNT;

  // FSM side: issues clear/start and the interval, watches completion.
  modport master (
    output CLR, START, DELAY,
    input  READY, BUSY, COUNT
  );

  // Timer side.
  modport slave (
    input  CLR, START, DELAY,
    output READY, BUSY, COUNT
  );

endinterface

// File: rtl/interval_timer_tick_gen.sv
// Prescaler: emits a one-cycle TICK every PRESCALE enabled cycles.
// Latency: first TICK is the PRESCALE-th enabled cycle after CLR.
// Backpressure: none; counting simply pauses while EN is low.
module tick_gen
  import timer_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  input  logic EN,
  output logic TICK
);

  localparam int            PW   = presc_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;
  logic          at_last;

  assign at_last = (presc == LAST);

  // TICK marks the cycle in which the prescaler holds its terminal value.
  assign TICK = EN && at_last;

  // Prescaler: cleared on any start/clear, counts 0..PRESCALE-1 while enabled, wraps.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc <= '0;
    end else if (CLR) begin
      presc <= '0;
    end else if (EN) begin
      if (at_last) begin
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/interval_timer.sv
// Interval timer: after START, counts DELAY prescaler ticks then holds READY until CLR/START.
// Latency: BUSY from the START edge, READY DELAY*PRESCALE edges later (same edge when DELAY==0).
// Backpressure: none; START while running is ignored, CLR always wins.
module interval_timer
  import timer_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int WIDTH    = DEF_WIDTH
) (
  input logic              CLK,
  input logic              RST,
  interval_timer_if.slave  bus
);

  state_t           state;
  logic [WIDTH-1:0] dly;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_inc;
  logic             ready;
  logic             busy;

  logic             idle_or_done;
  logic             start_acc;
  logic             presc_clr;
  logic             run_en;
  logic             tick;

  // A start is honoured only from a resting state and only when no clear competes with it.
  assign idle_or_done = (state == IDLE) || (state == DONE);
  assign start_acc    = !bus.CLR && bus.START && idle_or_done;

  // Every accepted start or clear restarts the prescaler phase from zero.
  assign presc_clr = bus.CLR || start_acc;
  assign run_en    = (state == RUN);

  assign count_inc = count + 1'b1;

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .CLK  (CLK),
    .RST  (RST),
    .CLR  (presc_clr),
    .EN   (run_en),
    .TICK (tick)
  );

  // State, latched interval, tick count and registered READY/BUSY, all updated together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      dly   <= '0;
      count <= '0;
      ready <= 1'b0;
      busy  <= 1'b0;
    end else if (bus.CLR) begin
      state <= IDLE;
      count <= '0;
      ready <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.START) begin
            dly   <= bus.DELAY;
            count <= '0;
            if (bus.DELAY == '0) begin
              state <= DONE;
              ready <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= RUN;
              ready <= 1'b0;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (tick) begin
            count <= count_inc;
            if (count_inc == dly) begin
              state <= DONE;
              ready <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
          ready <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.READY = ready;
  assign bus.BUSY  = busy;
  assign bus.COUNT = count;

endmodule
